// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU instruction sequencer: opcode classes,
// FSM state encoding and the decoded-instruction payload.
package alu_seq_pkg;

  localparam int unsigned CLS_W  = 4;
  localparam int unsigned FLAG_W = 4;

  localparam logic [CLS_W-1:0] CLS_NOP    = 4'h0;
  localparam logic [CLS_W-1:0] CLS_ALU    = 4'h1;
  localparam logic [CLS_W-1:0] CLS_LOAD   = 4'h2;
  localparam logic [CLS_W-1:0] CLS_READ   = 4'h3;
  localparam logic [CLS_W-1:0] CLS_JUMP   = 4'h4;
  localparam logic [CLS_W-1:0] CLS_BRANCH = 4'h5;
  localparam logic [CLS_W-1:0] CLS_HALT   = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH0 = 3'd1,
    ST_FETCH1 = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALTED = 3'd5
  } state_e;

  typedef struct packed {
    logic legal;
    logic wr;
    logic rd;
    logic jump;
    logic take;
    logic halt;
  } dec_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational instruction-class decode for the ALU sequencer.
// ALU_SEQ_BRANCH_EN enables JUMP/BRANCH; without it those classes decode as illegal.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [CLS_W-1:0]  cls,
  input  logic [FLAG_W-1:0] flags,
  input  logic [1:0]        flag_sel,
  output dec_t              dec_c
);

  logic take_c;

`ifdef ALU_SEQ_BRANCH_EN
  assign take_c = flags[flag_sel];
`else
  logic unused_flags;
  assign unused_flags = ^{flags, flag_sel};
  assign take_c       = 1'b0;
`endif

  always_comb begin
    dec_c = '0;
    case (cls)
      CLS_NOP: begin
        dec_c.legal = 1'b1;
      end
      CLS_ALU, CLS_LOAD: begin
        dec_c.legal = 1'b1;
        dec_c.wr    = 1'b1;
      end
      CLS_READ: begin
        dec_c.legal = 1'b1;
        dec_c.rd    = 1'b1;
      end
      CLS_HALT: begin
        dec_c.legal = 1'b1;
        dec_c.halt  = 1'b1;
      end
`ifdef ALU_SEQ_BRANCH_EN
      CLS_JUMP: begin
        dec_c.legal = 1'b1;
        dec_c.jump  = 1'b1;
      end
      CLS_BRANCH: begin
        dec_c.legal = 1'b1;
        dec_c.take  = take_c;
      end
`endif
      default: begin
        dec_c = '0;
      end
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Four-cycle fetch/decode/issue sequencer driving the ALU/register command port.
// ALU_SEQ_BRANCH_EN enables JUMP and BRANCH; otherwise they are illegal and halt.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  output logic [ADDR_WIDTH-1:0] prog_addr,
  output logic                  prog_rd_en,
  input  logic [DATA_WIDTH-1:0] prog_rd_data,
  output logic [DATA_WIDTH-1:0] opcode,
  output logic [DATA_WIDTH-1:0] operand,
  output logic [DATA_WIDTH-1:0] reg_write_data,
  output logic                  read_enable,
  output logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] reg_read_data,
  input  logic [FLAG_W-1:0]     alu_flags,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  halted,
  output logic                  error
);

  state_e                state, state_nx;
  logic [ADDR_WIDTH-1:0] pc, pc_nx;
  logic [ADDR_WIDTH-1:0] prog_addr_nx;
  logic                  prog_rd_en_nx;
  logic [DATA_WIDTH-1:0] opcode_nx;
  logic [DATA_WIDTH-1:0] operand_q, operand_nx;
  logic [DATA_WIDTH-1:0] reg_write_data_nx;
  logic                  read_enable_nx;
  logic                  write_enable_nx;
  logic                  rd_valid_nx;
  logic [DATA_WIDTH-1:0] rd_data_nx;
  logic                  busy_nx;
  logic                  halted_nx;
  logic                  error_nx;
  logic [CLS_W-1:0]      cls;
  logic [CLS_W-1:0]      fetch_cls;
  dec_t                  dec;

  assign cls       = opcode[DATA_WIDTH-1 -: CLS_W];
  assign fetch_cls = prog_rd_data[DATA_WIDTH-1 -: CLS_W];

  alu_seq_decode u_decode (
    .cls      (cls),
    .flags    (alu_flags),
    .flag_sel (opcode[1:0]),
    .dec_c    (dec)
  );

  // The operand word arrives from memory during EXEC; it is registered for WB.
  assign operand = (state == ST_EXEC) ? prog_rd_data : operand_q;

  // Next-state, next-PC and next-output logic.
  always_comb begin
    state_nx          = state;
    pc_nx             = pc;
    prog_addr_nx      = '0;
    prog_rd_en_nx     = 1'b0;
    opcode_nx         = '0;
    operand_nx        = '0;
    reg_write_data_nx = '0;
    read_enable_nx    = 1'b0;
    write_enable_nx   = 1'b0;
    rd_valid_nx       = 1'b0;
    rd_data_nx        = rd_data;
    error_nx          = error;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_FETCH0;
          pc_nx    = start_addr;
        end
      end
      ST_HALTED: begin
        if (start) begin
          state_nx = ST_FETCH0;
          pc_nx    = start_addr;
          error_nx = 1'b0;
        end
      end
      ST_FETCH0: begin
        state_nx = ST_FETCH1;
      end
      ST_FETCH1: begin
        state_nx       = ST_EXEC;
        opcode_nx      = prog_rd_data;
        read_enable_nx = (fetch_cls == CLS_READ);
      end
      ST_EXEC: begin
        state_nx        = ST_WB;
        opcode_nx       = opcode;
        operand_nx      = prog_rd_data;
        write_enable_nx = dec.wr;
        read_enable_nx  = dec.rd;
        if (cls == CLS_LOAD) begin
          reg_write_data_nx = prog_rd_data;
        end
        if (dec.jump || dec.take) begin
          pc_nx = ADDR_WIDTH'(prog_rd_data);
        end else begin
          pc_nx = pc + ADDR_WIDTH'(2);
        end
      end
      ST_WB: begin
        if (dec.rd) begin
          rd_valid_nx = 1'b1;
          rd_data_nx  = reg_read_data;
        end
        if (dec.halt || !dec.legal) begin
          state_nx = ST_HALTED;
          error_nx = !dec.legal;
        end else begin
          state_nx = ST_FETCH0;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    // Program-memory strobes lead the state they belong to by one register stage.
    if (state_nx == ST_FETCH0) begin
      prog_addr_nx  = pc_nx;
      prog_rd_en_nx = 1'b1;
    end else if (state_nx == ST_FETCH1) begin
      prog_addr_nx  = pc_nx + ADDR_WIDTH'(1);
      prog_rd_en_nx = 1'b1;
    end

    busy_nx   = (state_nx != ST_IDLE) && (state_nx != ST_HALTED);
    halted_nx = (state_nx == ST_HALTED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      pc             <= '0;
      prog_addr      <= '0;
      prog_rd_en     <= 1'b0;
      opcode         <= '0;
      operand_q      <= '0;
      reg_write_data <= '0;
      read_enable    <= 1'b0;
      write_enable   <= 1'b0;
      rd_valid       <= 1'b0;
      rd_data        <= '0;
      busy           <= 1'b0;
      halted         <= 1'b0;
      error          <= 1'b0;
    end else begin
      state          <= state_nx;
      pc             <= pc_nx;
      prog_addr      <= prog_addr_nx;
      prog_rd_en     <= prog_rd_en_nx;
      opcode         <= opcode_nx;
      operand_q      <= operand_nx;
      reg_write_data <= reg_write_data_nx;
      read_enable    <= read_enable_nx;
      write_enable   <= write_enable_nx;
      rd_valid       <= rd_valid_nx;
      rd_data        <= rd_data_nx;
      busy           <= busy_nx;
      halted         <= halted_nx;
      error          <= error_nx;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a program memory and a
// small register-file model (ALU op = sum of the two registers named by the operand).
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] start_addr;
  logic [15:0] prog_addr;
  logic        prog_rd_en;
  logic [15:0] prog_rd_data;
  logic [15:0] opcode;
  logic [15:0] operand;
  logic [15:0] reg_write_data;
  logic        read_enable;
  logic        write_enable;
  logic [15:0] reg_read_data;
  logic [3:0]  alu_flags;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        busy;
  logic        halted;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem  [0:65535];
  logic [15:0] regs [0:15];

  logic [15:0] fa [0:7];
  int          fn;
  int          halt_cyc;
  logic        en_seen;
  logic        err_at_halt;

  alu_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .start_addr     (start_addr),
    .prog_addr      (prog_addr),
    .prog_rd_en     (prog_rd_en),
    .prog_rd_data   (prog_rd_data),
    .opcode         (opcode),
    .operand        (operand),
    .reg_write_data (reg_write_data),
    .read_enable    (read_enable),
    .write_enable   (write_enable),
    .reg_read_data  (reg_read_data),
    .alu_flags      (alu_flags),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .busy           (busy),
    .halted         (halted),
    .error          (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (prog_rd_en) prog_rd_data <= mem[prog_addr];
  end

  always @(posedge clk) begin
    if (write_enable) begin
      if (opcode[15:12] == 4'h1) regs[opcode[3:0]] <= regs[operand[11:8]] + regs[operand[3:0]];
      else                       regs[opcode[3:0]] <= reg_write_data;
    end
  end

  assign reg_read_data = read_enable ? regs[opcode[3:0]] : 16'h0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [86:0] all_outs();
    return {prog_addr, prog_rd_en, opcode, operand, reg_write_data, read_enable,
            write_enable, rd_valid, rd_data, busy, halted, error};
  endfunction

  // Start at addr and record fetch addresses, first halted cycle and any enable activity.
  task automatic run_collect(input logic [15:0] addr, input int ncyc);
    fn = 0; halt_cyc = 0; en_seen = 1'b0; err_at_halt = 1'b0;
    start_addr = addr;
    start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      start = 1'b0;
      if (prog_rd_en && fn < 8) begin
        fa[fn] = prog_addr;
        fn++;
      end
      if (write_enable || read_enable || rd_valid) en_seen = 1'b1;
      if (halted && halt_cyc == 0) begin
        halt_cyc = c;
        err_at_halt = error;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; start_addr = 16'h1234; alu_flags = 4'h0;
    tick(); tick();
    checks++;
    if (all_outs() !== 87'h0) begin
      errors++;
      $display("FAIL reset_outputs actual=%h required=0", all_outs());
    end
    reset = 1'b0; start = 1'b0;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || prog_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_beats_start actual busy=%b rd_en=%b required busy=0 rd_en=0", busy, prog_rd_en);
    end
  endtask

  task automatic test_program();
    logic [31:0] we_bits;
    logic [31:0] rv_bits;
    logic [15:0] rv_data;
    we_bits = '0; rv_bits = '0; rv_data = '0;
    mem[16'h0000] = 16'h2001; mem[16'h0001] = 16'h0005;
    mem[16'h0002] = 16'h2002; mem[16'h0003] = 16'h0003;
    mem[16'h0004] = 16'h1003; mem[16'h0005] = 16'h0201;
    mem[16'h0006] = 16'h3003; mem[16'h0007] = 16'h0000;
    mem[16'h0008] = 16'hF000; mem[16'h0009] = 16'h0000;
    start_addr = 16'h0000;
    start = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      tick();
      start = (c == 5);
      if (c == 5) start_addr = 16'h0040;
      if (write_enable) we_bits[c] = 1'b1;
      if (rd_valid) begin
        rv_bits[c] = 1'b1;
        rv_data = rd_data;
      end
      if (c == 1) begin
        checks++;
        if (prog_addr !== 16'h0000 || prog_rd_en !== 1'b1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL fetch0_first actual addr=%h en=%b busy=%b required addr=0000 en=1 busy=1", prog_addr, prog_rd_en, busy);
        end
      end
      if (c == 2) begin
        checks++;
        if (prog_addr !== 16'h0001 || prog_rd_en !== 1'b1) begin
          errors++;
          $display("FAIL fetch1_first actual addr=%h en=%b required addr=0001 en=1", prog_addr, prog_rd_en);
        end
      end
      if (c == 4) begin
        checks++;
        if (reg_write_data !== 16'h0005 || opcode !== 16'h2001) begin
          errors++;
          $display("FAIL load_wb_bus actual wdata=%h op=%h required wdata=0005 op=2001", reg_write_data, opcode);
        end
      end
      if (c == 9) begin
        checks++;
        if (prog_addr !== 16'h0004) begin
          errors++;
          $display("FAIL start_ignored_busy actual addr=%h required addr=0004", prog_addr);
        end
      end
      if (c == 11 || c == 12) begin
        checks++;
        if (opcode !== 16'h1003 || operand !== 16'h0201) begin
          errors++;
          $display("FAIL alu_bus_c%0d actual op=%h opd=%h required op=1003 opd=0201", c, opcode, operand);
        end
      end
      if (c == 13) begin
        checks++;
        if (opcode !== 16'h0000 || operand !== 16'h0000) begin
          errors++;
          $display("FAIL bus_idle_between actual op=%h opd=%h required op=0000 opd=0000", opcode, operand);
        end
      end
      if (c == 15 || c == 16) begin
        checks++;
        if (read_enable !== 1'b1) begin
          errors++;
          $display("FAIL read_enable_c%0d actual=%b required=1", c, read_enable);
        end
      end
      if (c == 20) begin
        checks++;
        if (halted !== 1'b0) begin
          errors++;
          $display("FAIL halted_early actual=%b required=0", halted);
        end
      end
      if (c == 21) begin
        checks++;
        if (halted !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
          errors++;
          $display("FAIL halted_after_program actual h=%b b=%b e=%b required h=1 b=0 e=0", halted, busy, error);
        end
      end
    end
    checks++;
    if (we_bits !== 32'h0000_1110) begin
      errors++;
      $display("FAIL write_enable_pulses actual=%h required=00001110", we_bits);
    end
    checks++;
    if (rv_bits !== 32'h0002_0000 || rv_data !== 16'h0008) begin
      errors++;
      $display("FAIL rd_valid_result actual bits=%h data=%h required bits=00020000 data=0008", rv_bits, rv_data);
    end
  endtask

  task automatic test_jump();
    mem[16'h0100] = 16'h4000; mem[16'h0101] = 16'h0110;
    mem[16'h0110] = 16'hF000; mem[16'h0111] = 16'h0000;
    run_collect(16'h0100, 12);
`ifdef ALU_SEQ_BRANCH_EN
    checks++;
    if (fn !== 4 || {fa[0], fa[1], fa[2], fa[3]} !== 64'h0100_0101_0110_0111) begin
      errors++;
      $display("FAIL jump_fetch_seq actual n=%0d %h %h %h %h required n=4 0100 0101 0110 0111", fn, fa[0], fa[1], fa[2], fa[3]);
    end
    checks++;
    if (halt_cyc !== 9 || err_at_halt !== 1'b0 || en_seen !== 1'b0) begin
      errors++;
      $display("FAIL jump_halt actual cyc=%0d err=%b en=%b required cyc=9 err=0 en=0", halt_cyc, err_at_halt, en_seen);
    end
`else
    checks++;
    if (fn !== 2 || halt_cyc !== 5 || err_at_halt !== 1'b1 || en_seen !== 1'b0) begin
      errors++;
      $display("FAIL jump_illegal actual n=%0d cyc=%0d err=%b en=%b required n=2 cyc=5 err=1 en=0", fn, halt_cyc, err_at_halt, en_seen);
    end
`endif
  endtask

  task automatic test_branch();
    mem[16'h0200] = 16'h5002; mem[16'h0201] = 16'h0230;
    mem[16'h0202] = 16'hF000; mem[16'h0203] = 16'h0000;
    mem[16'h0230] = 16'hF000; mem[16'h0231] = 16'h0000;
    alu_flags = 4'b0100;
    run_collect(16'h0200, 12);
`ifdef ALU_SEQ_BRANCH_EN
    checks++;
    if (fn !== 4 || {fa[0], fa[1], fa[2], fa[3]} !== 64'h0200_0201_0230_0231) begin
      errors++;
      $display("FAIL branch_taken actual n=%0d %h %h %h %h required n=4 0200 0201 0230 0231", fn, fa[0], fa[1], fa[2], fa[3]);
    end
    alu_flags = 4'b0000;
    run_collect(16'h0200, 12);
    checks++;
    if (fn !== 4 || {fa[0], fa[1], fa[2], fa[3]} !== 64'h0200_0201_0202_0203) begin
      errors++;
      $display("FAIL branch_not_taken actual n=%0d %h %h %h %h required n=4 0200 0201 0202 0203", fn, fa[0], fa[1], fa[2], fa[3]);
    end
`else
    checks++;
    if (fn !== 2 || halt_cyc !== 5 || err_at_halt !== 1'b1) begin
      errors++;
      $display("FAIL branch_illegal actual n=%0d cyc=%0d err=%b required n=2 cyc=5 err=1", fn, halt_cyc, err_at_halt);
    end
`endif
    alu_flags = 4'b0000;
  endtask

  task automatic test_illegal();
    mem[16'h0300] = 16'h7000; mem[16'h0301] = 16'h0000;
    mem[16'h0310] = 16'hF000; mem[16'h0311] = 16'h0000;
    run_collect(16'h0300, 8);
    checks++;
    if (halt_cyc !== 5 || err_at_halt !== 1'b1 || en_seen !== 1'b0) begin
      errors++;
      $display("FAIL illegal_halt actual cyc=%0d err=%b en=%b required cyc=5 err=1 en=0", halt_cyc, err_at_halt, en_seen);
    end
    start_addr = 16'h0310;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (error !== 1'b0 || busy !== 1'b1 || halted !== 1'b0) begin
      errors++;
      $display("FAIL start_clears_error actual e=%b b=%b h=%b required e=0 b=1 h=0", error, busy, halted);
    end
    for (int c = 0; c < 6; c++) tick();
  endtask

  task automatic test_wrap();
    mem[16'hFFFE] = 16'h0000; mem[16'hFFFF] = 16'h0000;
    run_collect(16'hFFFE, 6);
    checks++;
    if (fn !== 4 || {fa[0], fa[1], fa[2], fa[3]} !== 64'hFFFE_FFFF_0000_0001) begin
      errors++;
      $display("FAIL pc_wrap actual n=%0d %h %h %h %h required n=4 fffe ffff 0000 0001", fn, fa[0], fa[1], fa[2], fa[3]);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic we_seen;
    we_seen = 1'b0;
    mem[16'h0400] = 16'h2001; mem[16'h0401] = 16'h0077;
    start_addr = 16'h0400;
    start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      start = 1'b0;
      if (write_enable) we_seen = 1'b1;
    end
    reset = 1'b1;
    tick();
    if (write_enable) we_seen = 1'b1;
    checks++;
    if (all_outs() !== 87'h0 || we_seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_instr actual outs=%h we=%b required outs=0 we=0", all_outs(), we_seen);
    end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (write_enable) we_seen = 1'b1;
    end
    checks++;
    if (busy !== 1'b0 || halted !== 1'b0 || we_seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle actual b=%b h=%b we=%b required b=0 h=0 we=0", busy, halted, we_seen);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    test_reset();
    test_program();
    test_jump();
    test_branch();
    test_illegal();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
